tdm_demux81: RTL and testbench

TDM_DEMUX81 -- requirements
Module: tdm_demux81

---
 rtl/tdm_demux81.sv | 93 +++++++++
 tb/tb_tdm_demux81.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux81.sv
// rtl/tdm_demux81.sv - 1:8 TDM demultiplexer with shadow slots and a separate frame register
// Optional macro TDM_DEMUX81_RESYNC_EN: SOF during FILL restarts the frame and pulses sync_err.
module tdm_demux81 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               din_sof,
  output logic [8*WIDTH-1:0] frame,
  output logic               frame_valid,
  output logic [2:0]         slot,
  output logic               busy,
  output logic               sync_err
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t           state;
  // Slot 7 is never stored: the 8th sample goes straight into frame.
  logic [WIDTH-1:0] shadow [7];

`ifdef TDM_DEMUX81_RESYNC_EN
  logic sync_err_q;
  assign sync_err = sync_err_q;
`else
  assign sync_err = 1'b0;
`endif

  assign busy = (state == FILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      slot        <= 3'd0;
      frame       <= '0;
      frame_valid <= 1'b0;
`ifdef TDM_DEMUX81_RESYNC_EN
      sync_err_q  <= 1'b0;
`endif
      for (int k = 0; k < 7; k++) begin
        shadow[k] <= '0;
      end
    end else begin
      frame_valid <= 1'b0;
`ifdef TDM_DEMUX81_RESYNC_EN
      sync_err_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (din_valid && din_sof) begin
            shadow[0] <= din;
            slot      <= 3'd1;
            state     <= FILL;
          end
        end
        FILL: begin
          if (din_valid) begin
`ifdef TDM_DEMUX81_RESYNC_EN
            if (din_sof) begin
              shadow[0]  <= din;
              slot       <= 3'd1;
              sync_err_q <= 1'b1;
            end else
`endif
            if (slot == 3'd7) begin
              for (int k = 0; k < 7; k++) begin
                frame[k*WIDTH +: WIDTH] <= shadow[k];
              end
              frame[7*WIDTH +: WIDTH] <= din;
              frame_valid <= 1'b1;
              slot        <= 3'd0;
              state       <= IDLE;
            end else begin
              for (int k = 0; k < 7; k++) begin
                if (slot == 3'(k)) begin
                  shadow[k] <= din;
                end
              end
              slot <= slot + 3'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          slot  <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux81.sv
// tb/tb_tdm_demux81.sv - directed and random checks of tdm_demux81 against a sample-queue model
module tb_tdm_demux81;

  localparam int WIDTH = 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [WIDTH-1:0]   din = '0;
  logic               din_valid = 1'b0;
  logic               din_sof = 1'b0;
  logic [8*WIDTH-1:0] frame;
  logic               frame_valid;
  logic [2:0]         slot;
  logic               busy;
  logic               sync_err;

  int n_cmp = 0;
  int n_err = 0;

  // Model: samples collected so far in the current frame, and last published frame.
  logic [WIDTH-1:0]   q [$];
  logic               in_frame = 1'b0;
  logic [8*WIDTH-1:0] exp_frame = '0;
  logic               exp_fv = 1'b0;
  logic               exp_se = 1'b0;
  int                 fv_count = 0;

`ifdef TDM_DEMUX81_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  tdm_demux81 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_sof(din_sof),
    .frame(frame), .frame_valid(frame_valid), .slot(slot), .busy(busy), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".frame"}, 32'(frame), 32'(exp_frame));
    check({tag, ".frame_valid"}, 32'(frame_valid), 32'(exp_fv));
    check({tag, ".slot"}, 32'(slot), in_frame ? 32'(q.size()) : 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'(in_frame));
    check({tag, ".sync_err"}, 32'(sync_err), 32'(exp_se));
  endtask

  task automatic model_step(input logic v, input logic sof, input logic [WIDTH-1:0] d);
    exp_fv = 1'b0;
    exp_se = 1'b0;
    if (v) begin
      if (!in_frame) begin
        if (sof) begin
          q.delete();
          q.push_back(d);
          in_frame = 1'b1;
        end
      end else if (RESYNC && sof) begin
        q.delete();
        q.push_back(d);
        exp_se = 1'b1;
      end else begin
        q.push_back(d);
        if (q.size() == 8) begin
          for (int k = 0; k < 8; k++) exp_frame[k*WIDTH +: WIDTH] = q[k];
          exp_fv = 1'b1;
          in_frame = 1'b0;
          q.delete();
        end
      end
    end
  endtask

  task automatic step(input string tag, input logic v, input logic sof, input logic [WIDTH-1:0] d);
    @(negedge clk);
    din_valid = v;
    din_sof = sof;
    din = d;
    @(posedge clk);
    model_step(v, sof, d);
    #1;
    if (frame_valid) fv_count++;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    din_valid = 1'b0;
    din_sof = 1'b0;
    #2 rst_n = 1'b0;
    q.delete();
    in_frame = 1'b0;
    exp_frame = '0;
    exp_fv = 1'b0;
    exp_se = 1'b0;
    #1;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] pat;
    int fv_before;

    // Reset state
    #3;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame 1,0,0,0,0,0,0,0 -> 8'b00000001
    step("f1.s0", 1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 8; i++) step("f1.data", 1'b1, 1'b0, 1'b0);
    check("f1.value", 32'(frame), 32'h01);
    step("f1.after", 1'b0, 1'b0, 1'b0);

    // One-hot walking frames with a 3-cycle gap after sample 4
    for (int f = 0; f < 8; f++) begin
      pat = 8'(1 << f);
      for (int i = 0; i < 8; i++) begin
        if (i == 4) begin
          for (int g = 0; g < 3; g++) begin
            step("onehot.gap", 1'b0, 1'b0, 1'b1);
            check("onehot.gap_slot", 32'(slot), 32'd4);
          end
        end
        step("onehot", 1'b1, (i == 0), pat[i]);
      end
      check("onehot.value", 32'(frame), 32'(pat));
    end

    // Non-SOF samples while IDLE are discarded
    for (int i = 0; i < 5; i++) step("idle_nosof", 1'b1, 1'b0, 1'b1);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) step("after_idle", 1'b1, (i == 0), pat[i]);
    check("after_idle.value", 32'(frame), 32'hA5);

    // Reset after 5 samples of a partial frame
    fv_before = fv_count;
    for (int i = 0; i < 5; i++) step("partial", 1'b1, (i == 0), 1'b1);
    pulse_reset("midreset");
    step("midreset.after", 1'b0, 1'b0, 1'b0);
    check("midreset.no_fv", 32'(fv_count), 32'(fv_before));

    // SOF arriving at slot 7, then 7 more samples
    for (int i = 0; i < 7; i++) step("resync.pre", 1'b1, (i == 0), 1'b0);
    check("resync.slot7", 32'(slot), 32'd7);
    fv_before = fv_count;
    step("resync.sof", 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step("resync.post", 1'b1, 1'b0, 1'b0);
    step("resync.tail", 1'b0, 1'b0, 1'b0);
    check("resync.fv_count", 32'(fv_count - fv_before), 32'd1);

    // Back-to-back frames: 16 consecutive valid cycles
    pulse_reset("b2b.reset");
    fv_before = fv_count;
    for (int i = 0; i < 16; i++) step("b2b", 1'b1, (i % 8 == 0), 1'((i * 5 + 3) >> 1));
    check("b2b.fv_count", 32'(fv_count - fv_before), 32'd2);

    // Random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset("rand.reset");
      else step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), WIDTH'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
